leaky_relu_array: RTL and testbench

LEAKY_RELU_ARRAY -- requirements
Module: leaky_relu_array

---
 rtl/leaky_relu_array.sv | 147 ++++++++++++++
 tb/tb_leaky_relu_array.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/leaky_relu_array.sv
// ---------------------------------------------------------------------------
// leaky_relu_array
//   LANES-wide two-stage pipelined activation unit on signed Q(WIDTH-FRAC).FRAC
//   words. Each transaction carries its own op (mode) and leak factor:
//     mode 0: pass x
//     mode 1: ReLU              (x > 0 ? x : 0)
//     mode 2: leaky ReLU        (x > 0 ? x : (x * leak) >>> FRAC)
//     mode 3: leaky derivative  (x > 0 ? 1.0 : leak)
//   Stage 1 captures the accepted vector (the multiply runs off these
//   registers); stage 2 selects the per-lane result and holds it under
//   backpressure. Latency is 2 cycles with ready_in held high.
//
// Optional feature macro: LEAKY_RELU_SAT_EN
//   defined   -> the shifted leak product saturates to the signed WIDTH range
//   undefined -> the shifted leak product wraps (low WIDTH bits kept)
//
// Ports
//   clk          single clock, all logic on posedge
//   rst          synchronous active-high reset, flushes the pipeline
//   valid_in     input vector valid
//   ready_out    block can accept an input vector this cycle
//   data_in      LANES signed words, lane i at [i*WIDTH +: WIDTH]
//   mode         per-transaction op select (see above)
//   leak_factor  signed Q-format leak, captured with the transaction
//   data_out     result vector, same lane packing
//   valid_out    data_out valid
//   ready_in     downstream accepts data_out this cycle
// ---------------------------------------------------------------------------
module leaky_relu_array #(
    parameter int LANES = 2,
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    output logic                     ready_out,
    input  logic [LANES*WIDTH-1:0]   data_in,
    input  logic [1:0]               mode,
    input  logic [WIDTH-1:0]         leak_factor,
    output logic [LANES*WIDTH-1:0]   data_out,
    output logic                     valid_out,
    input  logic                     ready_in
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;

    // Stage 1: captured transaction
    logic                   s1_valid_reg;
    logic [LANES*WIDTH-1:0] s1_data_reg;
    logic [1:0]             s1_mode_reg;
    logic [WIDTH-1:0]       s1_leak_reg;

    // Stage 2: result register driving the outputs
    logic                   s2_valid_reg;
    logic [LANES*WIDTH-1:0] s2_data_reg;

    logic                   s2_advance;
    logic                   s1_load;
    logic [LANES*WIDTH-1:0] result_next;

    // Stage 2 may take new data when it is empty or its word leaves this cycle;
    // stage 1 can then always hand its content forward.
    assign s2_advance = !s2_valid_reg || ready_in;
    assign ready_out  = !s1_valid_reg || s2_advance;
    assign s1_load    = valid_in && ready_out;

    assign data_out  = s2_data_reg;
    assign valid_out = s2_valid_reg;

    logic signed [2*WIDTH-1:0] leak_ext;
    assign leak_ext = {{WIDTH{s1_leak_reg[WIDTH-1]}}, s1_leak_reg};

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [WIDTH-1:0]          x;
            logic signed [2*WIDTH-1:0] x_ext;
            logic signed [2*WIDTH-1:0] product;
            logic [WIDTH-1:0]          leak_val;
            logic                      positive;
            logic [WIDTH-1:0]          lane_result;

            assign x        = s1_data_reg[gi*WIDTH +: WIDTH];
            assign x_ext    = {{WIDTH{x[WIDTH-1]}}, x};
            assign product  = x_ext * leak_ext;
            // zero counts as non-positive
            assign positive = !x[WIDTH-1] && (x != '0);

`ifdef LEAKY_RELU_SAT_EN
            localparam logic signed [2*WIDTH-1:0] SAT_MAX =
                {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
            localparam logic signed [2*WIDTH-1:0] SAT_MIN =
                {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
            logic signed [2*WIDTH-1:0] shifted;

            assign shifted  = product >>> FRAC;
            assign leak_val = (shifted > SAT_MAX) ? SAT_MAX[WIDTH-1:0] :
                              (shifted < SAT_MIN) ? SAT_MIN[WIDTH-1:0] :
                              shifted[WIDTH-1:0];
`else
            // two's-complement wrap: keep only the low WIDTH bits
            assign leak_val = WIDTH'(product >>> FRAC);
`endif

            always_comb begin
                lane_result = x;
                case (s1_mode_reg)
                    2'd0: lane_result = x;
                    2'd1: lane_result = positive ? x : '0;
                    2'd2: lane_result = positive ? x : leak_val;
                    2'd3: lane_result = positive ? ONE : s1_leak_reg;
                    default: lane_result = x;
                endcase
            end

            assign result_next[gi*WIDTH +: WIDTH] = lane_result;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
            s1_mode_reg  <= '0;
            s1_leak_reg  <= '0;
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
        end else begin
            if (s1_load) begin
                s1_valid_reg <= 1'b1;
                s1_data_reg  <= data_in;
                s1_mode_reg  <= mode;
                s1_leak_reg  <= leak_factor;
            end else if (s2_advance) begin
                s1_valid_reg <= 1'b0;
            end

            if (s2_advance) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    s2_data_reg <= result_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_leaky_relu_array.sv
module tb_leaky_relu_array;

    localparam int LANES = 2;
    localparam int W     = 16;
    localparam int FRAC  = 8;

    typedef logic [LANES*W-1:0] vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_in;
    logic       ready_out;
    vec_t       data_in;
    logic [1:0] mode;
    logic [W-1:0] leak_factor;
    vec_t       data_out;
    logic       valid_out;
    logic       ready_in;

    int errors = 0;
    int checks = 0;

    vec_t exp_q[$];
    vec_t out_log[$];
    int   n_out = 0;
    logic prev_stall = 1'b0;
    vec_t prev_data  = '0;

    leaky_relu_array #(.LANES(LANES), .WIDTH(W), .FRAC(FRAC)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_in    (data_in),
        .mode       (mode),
        .leak_factor(leak_factor),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic, floor division for the leak term.
    function automatic logic [W-1:0] lane_model(input logic [W-1:0] xu, input logic [1:0] m,
                                                 input logic [W-1:0] lku);
        longint x, lk, p, q;
        logic [63:0] qb;
        logic [W-1:0] one_q;
        x = longint'($signed(xu));
        lk = longint'($signed(lku));
        one_q = 1 << FRAC;
        if (m == 2'd0) return xu;
        if (x > 0) return (m == 2'd3) ? one_q : xu;
        if (m == 2'd1) return '0;
        if (m == 2'd3) return lku;
        p = x * lk;
        q = p / (longint'(1) << FRAC);
        if (p < 0 && (p % (longint'(1) << FRAC)) != 0) q = q - 1;
`ifdef LEAKY_RELU_SAT_EN
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
`endif
        qb = q;
        return qb[W-1:0];
    endfunction

    function automatic vec_t model_vec(input vec_t v, input logic [1:0] m, input logic [W-1:0] lk);
        vec_t r;
        for (int i = 0; i < LANES; i++) r[i*W +: W] = lane_model(v[i*W +: W], m, lk);
        return r;
    endfunction

    // Compare process: scoreboard, stall stability, unexpected outputs.
    always @(negedge clk) begin
        vec_t e;
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(valid_out), 64'd1);
                check("hold_data", 64'(data_out), 64'(prev_data));
            end
            if (valid_out && ready_in) begin
                out_log.push_back(data_out);
                n_out++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got 0x%0h, expected no output", data_out);
                end else begin
                    e = exp_q.pop_front();
                    $display("out #%0d data_out=0x%08h expected=0x%08h", n_out, data_out, e);
                    check("out_data", 64'(data_out), 64'(e));
                end
            end
            if (valid_in && ready_out)
                exp_q.push_back(model_vec(data_in, mode, leak_factor));
            prev_stall = valid_out && !ready_in;
            prev_data  = data_out;
        end
    end

    task automatic idle(input int n);
        valid_in = 1'b0;
        ready_in = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // One transaction into an empty pipe; checks exact 2-cycle latency and value.
    task automatic single(input string name, input vec_t x, input logic [1:0] m,
                          input logic [W-1:0] lk, input vec_t expv);
        valid_in = 1'b1; ready_in = 1'b1;
        data_in = x; mode = m; leak_factor = lk;
        @(posedge clk); #1;
        valid_in = 1'b0;
        check({name, "_lat1_valid"}, 64'(valid_out), 64'd0);
        @(posedge clk); #1;
        check({name, "_lat2_valid"}, 64'(valid_out), 64'd1);
        check({name, "_data"}, 64'(data_out), 64'(expv));
        idle(2);
    endtask

    initial begin
        vec_t bp_vec[4];
        vec_t sat_exp;
        int   saw_drop, idx, base;
        logic acc;

        rst = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
        data_in = '0; mode = '0; leak_factor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid_out", 64'(valid_out), 64'd0);
        check("reset_data_out", 64'(data_out), 64'd0);
        check("reset_ready_out", 64'(ready_out), 64'd1);
        rst = 1'b0;
        idle(2);

        // Pin the reference model with hand-computed values.
        check("model_leak", 64'(lane_model(16'hFE00, 2'd2, 16'h0080)), 64'h0000FF00);
        check("model_deriv", 64'(lane_model(16'h0000, 2'd3, 16'h0080)), 64'h00000080);
        check("model_alt", 64'(lane_model(16'hFC00, 2'd2, 16'h0040)), 64'h0000FF00);

        // Directed cases with literal expectations.
        single("leaky", {16'hFE00, 16'h0300}, 2'd2, 16'h0080, {16'hFF00, 16'h0300});
        single("relu",  {16'hFF00, 16'h0000}, 2'd1, 16'h0080, {16'h0000, 16'h0000});
        single("deriv", {16'hFF00, 16'h0000}, 2'd3, 16'h0080, {16'h0080, 16'h0080});
        single("deriv_pos", {16'h0000, 16'h0100}, 2'd3, 16'h0080, {16'h0080, 16'h0100});
        single("pass",  {16'h8000, 16'h7FFF}, 2'd0, 16'h0080, {16'h8000, 16'h7FFF});
`ifdef LEAKY_RELU_SAT_EN
        sat_exp = {16'h0001, 16'h7FFF};
`else
        sat_exp = {16'h0001, 16'h8000};
`endif
        single("sat", {16'h0001, 16'h8000}, 2'd2, 16'hFF00, sat_exp);

        // Backpressure: 4 back-to-back vectors, ready_in low for 3 cycles.
        bp_vec[0] = {16'hF000, 16'h0010};
        bp_vec[1] = {16'h0020, 16'hE000};
        bp_vec[2] = {16'hFFFF, 16'h0001};
        bp_vec[3] = {16'h1234, 16'h8001};
        base = n_out; idx = 0; saw_drop = 0;
        for (int c = 0; c < 20; c++) begin
            ready_in = !(c >= 2 && c <= 4);
            valid_in = (idx < 4);
            if (idx < 4) begin
                data_in = bp_vec[idx]; mode = 2'd2; leak_factor = 16'h0080;
            end
            @(negedge clk);
            if (valid_in && !ready_out) saw_drop++;
            acc = valid_in && ready_out;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        check("bp_ready_drop", 64'(saw_drop > 0), 64'd1);
        check("bp_all_accepted", 64'(idx), 64'd4);
        check("bp_delivered", 64'(n_out - base), 64'd4);
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);
        idle(2);

        // Reset with two transactions in flight.
        base = n_out;
        valid_in = 1'b1; ready_in = 1'b1; mode = 2'd0; leak_factor = 16'h0080;
        data_in = {16'hAAAA, 16'h5555};
        @(posedge clk); #1;
        data_in = {16'h1111, 16'h2222};
        @(posedge clk); #1;
        valid_in = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_valid_out", 64'(valid_out), 64'd0);
        check("midrst_data_out", 64'(data_out), 64'd0);
        check("midrst_ready_out", 64'(ready_out), 64'd1);
        rst = 1'b0;
        idle(5);
        check("midrst_no_output", 64'(n_out - base), 64'd0);

        // Alternating mode 0/2 on every transaction.
        out_log.delete();
        ready_in = 1'b1; leak_factor = 16'h0040;
        for (int i = 0; i < 6; i++) begin
            valid_in = 1'b1; data_in = {16'hFC00, 16'hFC00};
            mode = (i % 2 == 0) ? 2'd0 : 2'd2;
            @(posedge clk); #1;
        end
        idle(4);
        check("alt_count", 64'(out_log.size()), 64'd6);
        for (int i = 0; i < 6 && i < out_log.size(); i++) begin
            vec_t want;
            want = (i % 2 == 0) ? {16'hFC00, 16'hFC00} : {16'hFF00, 16'hFF00};
            check($sformatf("alt_%0d", i), 64'(out_log[i]), 64'(want));
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            valid_in = ($urandom_range(3) != 0);
            ready_in = ($urandom_range(2) != 0);
            mode = 2'($urandom_range(3));
            leak_factor = ($urandom_range(7) == 0) ? 16'h8000 : W'($urandom);
            for (int l = 0; l < LANES; l++) begin
                case ($urandom_range(5))
                    0: data_in[l*W +: W] = 16'h0000;
                    1: data_in[l*W +: W] = 16'h8000;
                    2: data_in[l*W +: W] = 16'h7FFF;
                    default: data_in[l*W +: W] = W'($urandom);
                endcase
            end
            @(posedge clk); #1;
        end
        idle(6);
        check("rand_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
